// File: rtl/ram_16k_loader_pkg.sv
// ram_loader_pkg: shared types and sizes for the ram_16k loader.
//   ADDR_WIDTH/DATA_WIDTH : RAM address and word widths
//   RAM_WORDS             : RAM depth (16384 words)
//   CNT_WIDTH             : width of the word-count input (wide enough for 16384)
//   state_e               : loader FSM states
//   sat_count()           : clamps a requested word count to the RAM depth
package ram_loader_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 16;
    localparam int RAM_WORDS  = 16384;
    localparam int CNT_WIDTH  = 15;

    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(RAM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY_ADDR,
        S_VERIFY_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_count(input logic [CNT_WIDTH-1:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

endpackage

// File: rtl/ram_16k_loader_if.sv
// ram_16k_loader_if: control, stream and RAM-port signals of the loader.
//   control : start, base_addr, word_count -> busy, done, error, checksum
//   stream  : in_data, in_valid -> in_ready
//   RAM     : ram_in, ram_addr, ram_load -> ram_out
// master = the loader, slave = host side plus RAM.
interface ram_16k_loader_if;
    import ram_loader_pkg::*;

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  word_count;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] ram_in;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_out;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        input  start, base_addr, word_count, in_data, in_valid, ram_out,
        output in_ready, ram_in, ram_addr, ram_load, busy, done, error, checksum
    );

    modport slave (
        output start, base_addr, word_count, in_data, in_valid, ram_out,
        input  in_ready, ram_in, ram_addr, ram_load, busy, done, error, checksum
    );

endinterface

// File: rtl/ram_16k_loader_checksum.sv
// ram_16k_loader_checksum: 16-bit modulo-2^16 accumulator.
//   clock, reset : clock, synchronous active-high reset
//   clr_i        : zero the sum (wins over en_i)
//   en_i         : add add_i to the sum at the edge
//   add_i        : word to add
//   sum_o        : current sum
module ram_16k_loader_checksum
    import ram_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] add_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i)
            sum_d = '0;
        else if (en_i)
            sum_d = sum_q + add_i;
    end

    always_ff @(posedge clock) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ram_16k_loader.sv
// ram_16k_loader: writes a valid/ready word stream into ram_16k from a base
// address, reads the range back and compares read/write checksums.
//   clock, reset : clock, synchronous active-high reset
//   bus          : ram_16k_loader_if.master (control, stream, RAM port, status)
module ram_16k_loader
    import ram_loader_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    ram_16k_loader_if.master bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] wr_sum, rd_sum, rd_final;
    logic [CNT_WIDTH-1:0]  req_count;
    logic                  start_ok, hs, rd_en, last;

    assign start_ok  = bus.start &&
                       (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign hs        = (state_q == S_WRITE) && bus.in_valid;
    assign rd_en     = (state_q == S_VERIFY_CHECK);
    assign req_count = sat_count(bus.word_count);
    // One counter serves both phases; it is cleared when WRITE hands over to verify.
    assign last      = (cnt_q == count_q - CNT_WIDTH'(1));
    // Final compare must include the word being read in this cycle.
    assign rd_final  = rd_sum + bus.ram_out;

    ram_16k_loader_checksum u_wr_sum (
        .clock (clock),
        .reset (reset),
        .clr_i (start_ok),
        .en_i  (hs),
        .add_i (bus.in_data),
        .sum_o (wr_sum)
    );

    ram_16k_loader_checksum u_rd_sum (
        .clock (clock),
        .reset (reset),
        .clr_i (start_ok),
        .en_i  (rd_en),
        .add_i (bus.ram_out),
        .sum_o (rd_sum)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    base_d  = bus.base_addr;
                    ptr_d   = bus.base_addr;
                    count_d = req_count;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    done_d  = (req_count == '0);
                    state_d = (req_count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (hs) begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last) begin
                        ptr_d   = base_q;
                        cnt_d   = '0;
                        state_d = S_VERIFY_ADDR;
                    end
                end
            end
            S_VERIFY_ADDR: state_d = S_VERIFY_CHECK;
            S_VERIFY_CHECK: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (!last) begin
                    state_d = S_VERIFY_ADDR;
                end else if (rd_final == wr_sum) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == S_WRITE);
        bus.ram_load = hs && !reset;
        bus.ram_in   = hs ? bus.in_data : '0;
        bus.ram_addr = ptr_q;
        bus.busy     = (state_q == S_WRITE) || (state_q == S_VERIFY_ADDR) ||
                       (state_q == S_VERIFY_CHECK);
        bus.done     = done_q;
        bus.error    = error_q;
        bus.checksum = wr_sum;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

endmodule
